// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
// Bundles the requester-side and transmitter-side handshake signals of the
// UART transmit scheduler.
//
// Signals:
//   req       per-requester level request
//   req_data  byte of requester i at bits [i*DATA_W +: DATA_W]
//   ack       one-cycle pulse per requester when its byte has been sent
//   tx_start  start strobe to the transmitter
//   tx_enable enable to the transmitter, held for the whole frame
//   tx_data   byte presented to the transmitter
//   tx_done   done pulse from the transmitter
//   tx_busy   busy level from the transmitter
//
// Modports:
//   master  scheduler view (drives ack and the tx_* controls)
//   slave   environment view (requesters and transmitter)
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_start;
  logic                      tx_enable;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      tx_busy;

  modport master (
    input  req, req_data, tx_done, tx_busy,
    output ack, tx_start, tx_enable, tx_data
  );

  modport slave (
    output req, req_data, tx_done, tx_busy,
    input  ack, tx_start, tx_enable, tx_data
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter between NUM_REQ byte requesters. Requests are
// arbitrated round-robin; the winning byte is latched and held on tx_data for
// the whole frame, the transmitter start/enable handshake is sequenced, and the
// winner receives a one-cycle ack when the frame completes.
//
// Optional feature (macro UART_TX_SCHED_TIMEOUT_EN): every wait state is bounded
// by TIMEOUT cycles; on expiry the frame is aborted without ack and the sticky
// error flag is raised (cleared by err_clr). Without the macro the FSM waits
// indefinitely, error is constant 0 and err_clr is ignored.
//
// Ports:
//   tx_clk      transmitter/baud clock
//   rst_n       synchronous active-low reset (shared with the transmitter)
//   arb_enable  1 = new grants allowed
//   err_clr     clears the sticky error flag (optional feature)
//   bus         handshake bundle, master modport
//   grant_id    current/last granted requester
//   active      transfer in progress
//   error       sticky timeout flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                       tx_clk,
  input  logic                       rst_n,
  input  logic                       arb_enable,
  input  logic                       err_clr,
  uart_tx_scheduler_if.master        bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       error
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACK       = 3'd4
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    ABORT     = 3'd5
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                start_q, start_d;
  logic                enable_q, enable_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                active_q, active_d;
  logic                error_q, error_d;
  logic [ID_W:0]       pick_s;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                expired_s;
`else
  // err_clr and TIMEOUT only matter when the timeout feature is built in.
  logic                unused_cfg_s;
  assign unused_cfg_s = err_clr ^ (TIMEOUT > 0);
`endif

  // Round-robin pick: first set request scanning from last+1 with wrap-around.
  // Returns {found, index}; the just-served requester is scanned last.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    int            c;
    res = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (int'(last) + i) % NUM_REQ;
      if (!res[ID_W] && r[c]) begin
        res = {1'b1, c[ID_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s = rr_pick(bus.req, last_q);

`ifdef UART_TX_SCHED_TIMEOUT_EN
  assign expired_s = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // that every port is driven straight from a flop.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    data_d   = data_q;
    start_d  = 1'b0;
    enable_d = enable_q;
    ack_d    = '0;
    active_d = active_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    error_d  = error_q & ~err_clr;
    cnt_d    = cnt_q + CNT_W'(1);
`else
    error_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (arb_enable && pick_s[ID_W]) begin
          state_d  = LAUNCH;
          grant_d  = pick_s[ID_W-1:0];
          data_d   = bus.req_data[pick_s[ID_W-1:0]*DATA_W +: DATA_W];
          start_d  = 1'b1;
          enable_d = 1'b1;
          active_d = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end

      LAUNCH: begin
        state_d = WAIT_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          cnt_d   = '0;
        end else if (expired_s) begin
          state_d  = ABORT;
          error_d  = 1'b1;
          enable_d = 1'b0;
          last_d   = grant_q;
          active_d = 1'b0;
`endif
        end else begin
          state_d = WAIT_BUSY;
        end
      end

      WAIT_DONE: begin
        if (bus.tx_done) begin
          state_d        = ACK;
          ack_d[grant_q] = 1'b1;
          last_d         = grant_q;
          active_d       = 1'b0;
          enable_d       = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        end else if (expired_s) begin
          state_d  = ABORT;
          error_d  = 1'b1;
          enable_d = 1'b0;
          last_d   = grant_q;
          active_d = 1'b0;
`endif
        end else begin
          state_d = WAIT_DONE;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

`ifdef UART_TX_SCHED_TIMEOUT_EN
      ABORT: begin
        state_d = IDLE;
      end
`endif

      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= ID_W'(NUM_REQ - 1);
      grant_q  <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      enable_q <= 1'b0;
      ack_q    <= '0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      start_q  <= start_d;
      enable_q <= enable_d;
      ack_q    <= ack_d;
      active_q <= active_d;
      error_q  <= error_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.tx_start  = start_q;
  assign bus.tx_enable = enable_q;
  assign bus.tx_data   = data_q;
  assign grant_id      = grant_q;
  assign active        = active_q;
  assign error         = error_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Scoreboard bench: stimulus pushes the expected {requester, byte} of every
// frame it provokes; a monitor pops and checks on each tx_start and each ack.
// A small transmitter model answers tx_start with busy/done and checks that
// tx_data stays stable through the frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT   = 32;
  localparam int FRAME_LEN = 6;

  logic       tx_clk = 1'b0;
  logic       rst_n;
  logic       arb_enable;
  logic       err_clr;
  logic [1:0] grant_id;
  logic       active;
  logic       error;

  always #5 tx_clk = ~tx_clk;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .tx_clk    (tx_clk),
    .rst_n     (rst_n),
    .arb_enable(arb_enable),
    .err_clr   (err_clr),
    .bus       (bus),
    .grant_id  (grant_id),
    .active    (active),
    .error     (error)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
  } frame_t;

  frame_t exp_q[$];
  frame_t ack_exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     n_start = 0;
  int     last_ack_cyc = -1;
  int     last_gap = -1;
  logic   stall = 1'b0;
  logic   prev_start = 1'b0;
  logic   prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [7:0] data);
    frame_t f;
    f.id = id;
    f.data = data;
    exp_q.push_back(f);
  endtask

  // Monitor: pops the scoreboard on tx_start, checks the matching ack.
  initial begin
    frame_t f;
    forever begin
      @(negedge tx_clk);
      cyc++;
      if (!rst_n) begin
        ack_exp_q.delete();
        last_ack_cyc = -1;
      end else begin
        if (bus.tx_start) begin
          n_start++;
          check("start_single_cycle", 32'(prev_start), 32'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_start: tx_data=0x%0h grant_id=%0d with no frame expected",
                     bus.tx_data, grant_id);
          end else begin
            f = exp_q.pop_front();
            check("start_grant_id", 32'(grant_id), 32'(f.id));
            check("start_tx_data", 32'(bus.tx_data), 32'(f.data));
            check("start_active", 32'(active), 32'd1);
            check("start_tx_enable", 32'(bus.tx_enable), 32'd1);
            ack_exp_q.push_back(f);
          end
          if (last_ack_cyc >= 0) begin
            last_gap = cyc - last_ack_cyc;
            check("ack_to_start_gap_ge2", 32'(last_gap >= 2), 32'd1);
          end
        end
        if (|bus.ack) begin
          check("ack_single_cycle", 32'(prev_ack), 32'd0);
          if (ack_exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: ack=0x%0h with no frame in flight", bus.ack);
          end else begin
            f = ack_exp_q.pop_front();
            check("ack_onehot", 32'(bus.ack), 32'd1 << f.id);
            check("ack_tx_data_held", 32'(bus.tx_data), 32'(f.data));
            check("ack_active_low", 32'(active), 32'd0);
          end
          last_ack_cyc = cyc;
        end
      end
      prev_start = bus.tx_start;
      prev_ack = |bus.ack;
    end
  end

  // Transmitter model: busy two cycles after start, done after FRAME_LEN more.
  initial begin
    int         xm_state;
    int         xm_cnt;
    logic [7:0] xm_data;
    xm_state = 0;
    xm_cnt = 0;
    xm_data = 8'h00;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge tx_clk);
      if (!rst_n) begin
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        xm_state = 0;
      end else begin
        case (xm_state)
          0: begin
            bus.tx_done = 1'b0;
            if (bus.tx_start && !stall) begin
              xm_data = bus.tx_data;
              xm_cnt = 0;
              xm_state = 1;
            end
          end
          1: begin
            xm_cnt++;
            if (xm_cnt == 2) begin
              bus.tx_busy = 1'b1;
              xm_cnt = 0;
              xm_state = 2;
            end
          end
          default: begin
            check("tx_data_stable", 32'(bus.tx_data), 32'(xm_data));
            check("tx_enable_in_frame", 32'(bus.tx_enable), 32'd1);
            xm_cnt++;
            if (xm_cnt == FRAME_LEN) begin
              bus.tx_done = 1'b1;
              bus.tx_busy = 1'b0;
              xm_state = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    arb_enable = 1'b1;
    err_clr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, 32'(bus.ack), 32'd0);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({tag, "_tx_enable"}, 32'(bus.tx_enable), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic wait_acks(input int n, input int budget);
    int got = 0;
    int t = 0;
    while (got < n && t < budget) begin
      @(negedge tx_clk);
      t++;
      if (|bus.ack) got++;
    end
    check("acks_within_budget", 32'(got), 32'(n));
  endtask

  task automatic wait_start(input int budget);
    int   t = 0;
    logic seen = 1'b0;
    while (!seen && t < budget) begin
      @(negedge tx_clk);
      t++;
      seen = bus.tx_start;
    end
    check("start_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic wait_busy(input int budget);
    int   t = 0;
    logic seen = 1'b0;
    while (!seen && t < budget) begin
      @(negedge tx_clk);
      t++;
      seen = bus.tx_busy;
    end
    check("busy_within_budget", 32'(seen), 32'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int ns;
    rst_n = 1'b0;
    arb_enable = 1'b1;
    err_clr = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Single request: one-cycle latency, req dropped after grant.
    bus.req_data[0*8 +: 8] = 8'hA5;
    push(0, 8'hA5);
    bus.req = 4'b0001;
    tick();
    check("latency_tx_start", 32'(bus.tx_start), 32'd1);
    check("latency_active", 32'(active), 32'd1);
    bus.req = 4'b0000;
    wait_acks(1, 60);
    repeat (3) tick();

    // Two simultaneous held requests: 0 then 2, minimum gap 2.
    do_reset();
    bus.req_data[0*8 +: 8] = 8'h11;
    bus.req_data[2*8 +: 8] = 8'h22;
    push(0, 8'h11);
    push(2, 8'h22);
    bus.req = 4'b0101;
    wait_acks(2, 120);
    bus.req = 4'b0000;
    check("back_to_back_gap", 32'(last_gap), 32'd2);
    repeat (3) tick();

    // Fairness: all four held for 8 frames.
    do_reset();
    bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int i = 0; i < 8; i++) begin
      push(i % 4, 8'h10 + 8'(17 * (i % 4)));
    end
    bus.req = 4'b1111;
    wait_acks(8, 400);
    bus.req = 4'b0000;
    repeat (3) tick();

    // Gating: disabled, then enabled, data changed after grant, disabled in WAIT_DONE.
    do_reset();
    arb_enable = 1'b0;
    bus.req_data[1*8 +: 8] = 8'h3C;
    bus.req = 4'b0010;
    ns = n_start;
    repeat (10) tick();
    check("no_start_when_disabled", 32'(n_start), 32'(ns));
    push(1, 8'h3C);
    arb_enable = 1'b1;
    wait_start(10);
    bus.req_data[1*8 +: 8] = 8'hFF;
    wait_busy(20);
    tick();
    tick();
    arb_enable = 1'b0;
    wait_acks(1, 60);
    ns = n_start;
    repeat (15) tick();
    check("no_grant_after_disable", 32'(n_start), 32'(ns));
    bus.req = 4'b0000;
    arb_enable = 1'b1;
    repeat (3) tick();

    // Reset for one cycle during WAIT_DONE.
    do_reset();
    bus.req_data[3*8 +: 8] = 8'h5A;
    push(3, 8'h5A);
    bus.req = 4'b1000;
    wait_start(10);
    bus.req = 4'b0000;
    wait_busy(20);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_values("mid_reset");
    rst_n = 1'b1;
    repeat (15) tick();
    bus.req_data[1*8 +: 8] = 8'h77;
    push(1, 8'h77);
    bus.req = 4'b0010;
    wait_start(10);
    bus.req = 4'b0000;
    wait_acks(1, 60);
    repeat (3) tick();

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Timeout: transmitter never goes busy.
    do_reset();
    stall = 1'b1;
    bus.req_data[0*8 +: 8] = 8'hC3;
    bus.req_data[1*8 +: 8] = 8'h96;
    push(0, 8'hC3);
    bus.req = 4'b0011;
    wait_start(10);
    repeat (32) @(negedge tx_clk);
    check("timeout_not_early_error", 32'(error), 32'd0);
    check("timeout_not_early_enable", 32'(bus.tx_enable), 32'd1);
    @(negedge tx_clk);
    check("abort_error", 32'(error), 32'd1);
    check("abort_active", 32'(active), 32'd0);
    check("abort_tx_enable", 32'(bus.tx_enable), 32'd0);
    check("abort_no_ack", 32'(bus.ack), 32'd0);
    if (ack_exp_q.size() > 0) void'(ack_exp_q.pop_front());
    stall = 1'b0;
    push(1, 8'h96);
    wait_start(10);
    bus.req = 4'b0000;
    wait_acks(1, 60);
    check("error_sticky", 32'(error), 32'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("error_cleared", 32'(error), 32'd0);
    repeat (3) tick();
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
